// File: rtl/shift_rows_pipe_if.sv
// Handshake bundle for the ShiftRows pipeline stage: input side (valid/ready/mode/data)
// and output side (valid/ready/data/count). Latency: n/a (wiring only).
// Backpressure: in_ready/out_ready carry the flow control; slave = the stage, master = its driver.
interface shift_rows_pipe_if #(
  parameter int NB = 4
);
  localparam int W = 32 * NB;

  logic         in_valid;
  logic         in_ready;
  logic         in_mode;
  logic [0:W-1] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [0:W-1] out_data;
  logic [1:0]   out_count;

  modport master (
    output in_valid, in_mode, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_count
  );

  modport slave (
    input  in_valid, in_mode, in_data, out_ready,
    output in_ready, out_valid, out_data, out_count
  );
endinterface

// File: rtl/shift_rows_pipe.sv
// Rijndael ShiftRows (in_mode=1) / InvShiftRows (in_mode=0) on an NB-column state, registered into a 2-entry FIFO.
// Latency: 1 cycle from accept to out_valid when the buffer is empty; 1 word/cycle sustained.
// Backpressure: in_ready = buffer not full, derived from state only (no in->out combinational path).
// Ports: clk, rst_n (async active-low); bus = slave side of shift_rows_pipe_if
//   (in_valid/in_ready/in_mode/in_data, out_valid/out_ready/out_data/out_count).
module shift_rows_pipe #(
  parameter int NB      = 4,
  parameter bit FWD_RST = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  shift_rows_pipe_if.slave   bus
);
  localparam int W = 32 * NB;

  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
    $error("shift_rows_pipe: NB must be 4, 6 or 8");
  end
  if (FWD_RST != 1'b0) begin : g_bad_fwd_rst
    $error("shift_rows_pipe: FWD_RST is reserved and must be 0");
  end

  // Row rotation amount; the 256-bit block uses the wider 3/4 offsets on rows 2 and 3.
  function automatic int row_shift(input int r);
    if (NB == 8 && r >= 2) return r + 1;
    return r;
  endfunction

  // Byte b = 4*col + row sits at [8*b +: 8]; with the ascending range byte 0 is the MSB.
  logic [0:W-1] shifted;

  for (genvar c = 0; c < NB; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int S  = row_shift(r);
      localparam int SF = (c + S) % NB;
      localparam int SI = (c + NB - S) % NB;
      assign shifted[8*(4*c+r) +: 8] = bus.in_mode ? bus.in_data[8*(4*SF+r) +: 8]
                                                   : bus.in_data[8*(4*SI+r) +: 8];
    end
  end

  // Two-entry ring buffer; head entry drives out_data directly.
  logic [0:W-1] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         full;
  logic         not_empty;
  logic         accept;
  logic         deliver;

  assign full      = (count == 2'd2);
  assign not_empty = (count != 2'd0);
  assign accept    = bus.in_valid & ~full;
  assign deliver   = not_empty & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= shifted;
        wr_ptr      <= ~wr_ptr;
      end
      if (deliver) begin
        rd_ptr <= ~rd_ptr;
      end
      // Simultaneous accept and deliver leaves the occupancy unchanged.
      case ({accept, deliver})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign bus.in_ready  = ~full;
  assign bus.out_valid = not_empty;
  assign bus.out_data  = mem[rd_ptr];
  assign bus.out_count = count;
endmodule

// File: tb/tb_shift_rows_pipe.sv
// Bench for shift_rows_pipe: directed NB=4 checks (known vectors, fill/stall, accept+deliver, async reset)
// and a randomized NB=8 stream checked against a row-rotation reference model with an in-order scoreboard.
// Inputs driven #1 after the rising edge; outputs sampled at the same point.
module tb_shift_rows_pipe;
  logic clk;
  logic rst_n;

  shift_rows_pipe_if #(.NB(4)) bus4 ();
  shift_rows_pipe_if #(.NB(8)) bus8 ();

  shift_rows_pipe #(.NB(4), .FWD_RST(1'b0)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
  shift_rows_pipe #(.NB(8), .FWD_RST(1'b0)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  typedef logic [31:0][7:0] st_t;  // element b = state byte b

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: each row r is a ring of nb bytes, rotated left (forward) or right (inverse) by its offset.
  function automatic st_t ref_shift(input st_t st, input int nb, input bit fwd);
    int         offs [4];
    st_t        res;
    logic [7:0] row [8];
    logic [7:0] tmp;
    if (nb == 8) offs = '{0, 1, 3, 4};
    else         offs = '{0, 1, 2, 3};
    res = st;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < nb; c++) row[c] = st[4*c + r];
      for (int k = 0; k < offs[r]; k++) begin
        if (fwd) begin
          tmp = row[0];
          for (int c = 0; c < nb - 1; c++) row[c] = row[c + 1];
          row[nb - 1] = tmp;
        end else begin
          tmp = row[nb - 1];
          for (int c = nb - 1; c > 0; c--) row[c] = row[c - 1];
          row[0] = tmp;
        end
      end
      for (int c = 0; c < nb; c++) res[4*c + r] = row[c];
    end
    return res;
  endfunction

  function automatic st_t to_st(input logic [0:255] d);
    st_t st;
    for (int b = 0; b < 32; b++) st[b] = d[8*b +: 8];
    return st;
  endfunction

  function automatic logic [0:255] from_st(input st_t st);
    logic [0:255] d;
    for (int b = 0; b < 32; b++) d[8*b +: 8] = st[b];
    return d;
  endfunction

  function automatic logic [0:127] model4(input logic [0:127] d, input bit fwd);
    logic [0:255] wide;
    wide = from_st(ref_shift(to_st({d, 128'h0}), 4, fwd));
    return wide[0:127];
  endfunction

  function automatic logic [0:255] model8(input logic [0:255] d, input bit fwd);
    return from_st(ref_shift(to_st(d), 8, fwd));
  endfunction

  function automatic logic [0:255] rand256();
    logic [0:255] d;
    for (int i = 0; i < 8; i++) d[32*i +: 32] = $urandom;
    return d;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [0:127] x4, fwd_res, wa, wb, wc, wd, we;
  bit           ma, mb, md, me;
  logic [0:255] rd8, exp8;
  logic [0:255] q8 [$];
  int           sent, cyc;

  initial begin
    rst_n = 1'b0;
    bus4.in_valid = 1'b0; bus4.in_mode = 1'b0; bus4.in_data = '0; bus4.out_ready = 1'b0;
    bus8.in_valid = 1'b0; bus8.in_mode = 1'b0; bus8.in_data = '0; bus8.out_ready = 1'b0;
    x4 = 128'h000102030405060708090A0B0C0D0E0F;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 256'(bus4.out_valid), 256'(0));
    chk("rst_out_count", 256'(bus4.out_count), 256'(0));
    chk("rst_in_ready",  256'(bus4.in_ready),  256'(1));
    chk("rst_out_data",  256'(bus4.out_data),  256'(0));
    chk("rst_in_ready8", 256'(bus8.in_ready),  256'(1));
    rst_n = 1'b1;
    step();

    // Known inverse vector, one-cycle latency
    bus4.in_valid = 1'b1; bus4.in_mode = 1'b0; bus4.in_data = x4;
    step();
    bus4.in_valid = 1'b0;
    chk("inv_valid", 256'(bus4.out_valid), 256'(1));
    chk("inv_const", 256'(bus4.out_data), 256'(128'h000D0A0704010E0B0805020F0C090603));
    chk("inv_model", 256'(bus4.out_data), 256'(model4(x4, 1'b0)));
    chk("inv_count", 256'(bus4.out_count), 256'(1));
    bus4.out_ready = 1'b1;
    step();
    bus4.out_ready = 1'b0;
    chk("drain_count", 256'(bus4.out_count), 256'(0));
    chk("drain_valid", 256'(bus4.out_valid), 256'(0));

    // Known forward vector, then feed result back inverse while delivering (accept+deliver at count=1)
    bus4.in_valid = 1'b1; bus4.in_mode = 1'b1; bus4.in_data = x4;
    step();
    bus4.in_valid = 1'b0;
    chk("fwd_const", 256'(bus4.out_data), 256'(128'h00050A0F04090E03080D02070C01060B));
    chk("fwd_model", 256'(bus4.out_data), 256'(model4(x4, 1'b1)));
    fwd_res = bus4.out_data;
    bus4.in_valid = 1'b1; bus4.in_mode = 1'b0; bus4.in_data = fwd_res; bus4.out_ready = 1'b1;
    step();
    bus4.in_valid = 1'b0;
    chk("chain_count", 256'(bus4.out_count), 256'(1));
    chk("chain_ident", 256'(bus4.out_data), 256'(x4));
    step();
    bus4.out_ready = 1'b0;
    chk("chain_drain", 256'(bus4.out_count), 256'(0));

    // Fill: push 3 with out_ready=0, third is held off; release drains in order
    wa = rand256(); wb = rand256(); wc = rand256();
    ma = 1'($urandom_range(0, 1)); mb = ~ma;
    bus4.in_valid = 1'b1; bus4.in_mode = ma; bus4.in_data = wa;
    step();
    chk("fill1_count", 256'(bus4.out_count), 256'(1));
    chk("fill1_ready", 256'(bus4.in_ready),  256'(1));
    bus4.in_mode = mb; bus4.in_data = wb;
    step();
    chk("fill2_count", 256'(bus4.out_count), 256'(2));
    chk("fill2_ready", 256'(bus4.in_ready),  256'(0));
    bus4.in_mode = 1'b1; bus4.in_data = wc;
    step();
    chk("fill3_count", 256'(bus4.out_count), 256'(2));
    chk("fill3_ready", 256'(bus4.in_ready),  256'(0));
    chk("fill3_head",  256'(bus4.out_data),  256'(model4(wa, ma)));
    bus4.in_valid = 1'b0; bus4.out_ready = 1'b1;
    step();
    chk("rel1_data",  256'(bus4.out_data),  256'(model4(wb, mb)));
    chk("rel1_count", 256'(bus4.out_count), 256'(1));
    chk("rel1_ready", 256'(bus4.in_ready),  256'(1));
    step();
    chk("rel2_count", 256'(bus4.out_count), 256'(0));
    bus4.out_ready = 1'b0;

    // Accept and deliver in the same cycle at count=1
    wd = rand256(); we = rand256();
    md = 1'($urandom_range(0, 1)); me = ~md;
    bus4.in_valid = 1'b1; bus4.in_mode = md; bus4.in_data = wd;
    step();
    chk("sim_head", 256'(bus4.out_data), 256'(model4(wd, md)));
    bus4.in_mode = me; bus4.in_data = we; bus4.out_ready = 1'b1;
    step();
    bus4.in_valid = 1'b0;
    chk("sim_count", 256'(bus4.out_count), 256'(1));
    chk("sim_next",  256'(bus4.out_data),  256'(model4(we, me)));
    step();
    bus4.out_ready = 1'b0;
    chk("sim_drain", 256'(bus4.out_count), 256'(0));

    // Asynchronous reset while full, checked before any clock edge
    bus4.in_valid = 1'b1; bus4.in_mode = 1'b1; bus4.in_data = rand256();
    step();
    bus4.in_data = rand256();
    step();
    bus4.in_valid = 1'b0;
    chk("prerst_count", 256'(bus4.out_count), 256'(2));
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 256'(bus4.out_valid), 256'(0));
    chk("arst_count", 256'(bus4.out_count), 256'(0));
    chk("arst_ready", 256'(bus4.in_ready),  256'(1));
    chk("arst_data",  256'(bus4.out_data),  256'(0));
    step();
    rst_n = 1'b1;
    step();

    // Randomized NB=8 stream against scoreboard
    sent = 0;
    cyc  = 0;
    while ((sent < 1000 || q8.size() != 0) && cyc < 20000) begin
      chk("r8_count", 256'(bus8.out_count), 256'(q8.size()));
      chk("r8_valid", 256'(bus8.out_valid), 256'(q8.size() != 0));
      bus8.out_ready = ($urandom_range(0, 3) != 0);
      if (bus8.out_valid && bus8.out_ready) begin
        exp8 = q8.pop_front();
        rd8  = bus8.out_data;
        chk("r8_data", 256'(rd8), 256'(exp8));
      end
      if (sent < 1000) begin
        bus8.in_valid = ($urandom_range(0, 3) != 0);
        bus8.in_mode  = 1'($urandom_range(0, 1));
        bus8.in_data  = rand256();
      end else begin
        bus8.in_valid = 1'b0;
      end
      if (bus8.in_valid && bus8.in_ready) begin
        q8.push_back(model8(bus8.in_data, bus8.in_mode));
        sent++;
      end
      step();
      cyc++;
    end
    bus8.in_valid  = 1'b0;
    bus8.out_ready = 1'b0;
    chk("r8_all_sent",    256'(sent),       256'(1000));
    chk("r8_all_drained", 256'(q8.size()),  256'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
